z80_busrq_dma: RTL and testbench

Bus-master DMA controller that shares the tv80s memory bus with the CPU through the Z80 BUSRQ/BUSAK handshake. It accepts a memory-to-memory block-copy command and requests the bus with busrq_n. Once the CPU grants the bus with busak_n, it drives the shared memory port to copy the block, then releases the bus. It sits between the test harness/peripherals and the memory mux that selects CPU or DMA drive via dma_bus_en.

---
 rtl/z80_busrq_dma.sv | 204 ++++++++++++++++++++
 tb/tb_z80_busrq_dma.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_busrq_dma.sv
`default_nettype none
//============================================================================
// Module      : z80_busrq_dma
// Description : Bus-master DMA for the tv80s memory bus. Takes a block-copy
//               command, requests the bus with busrq_n, copies the block over
//               the shared memory port once busak_n grants it (3 cycles per
//               byte), then hands the bus back and pulses done.
// Ports       : clk/reset      - clock, synchronous active-high reset
//               cmd_*          - command handshake (src, dst, len)
//               busy/done/err  - status; done (and err on grant timeout)
//                                pulse for one cycle
//               busrq_n/busak_n- Z80 bus request / acknowledge
//               dma_*          - shared memory port; dma_bus_en selects the
//                                DMA side of the memory mux
// Revision    : 1.0 - initial release
//============================================================================
module z80_busrq_dma #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_src,
  input  logic [15:0]      cmd_dst,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             busrq_n,
  input  logic             busak_n,
  output logic             dma_bus_en,
  output logic [15:0]      dma_a,
  output logic [7:0]       dma_do,
  input  logic [7:0]       dma_di,
  output logic             dma_mreq_n,
  output logic             dma_rd_n,
  output logic             dma_wr_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_RD2  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_REL  = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  // The timeout compares the count before it increments, so the counter only
  // has to hold 0..ACK_TIMEOUT-1.
  localparam int             TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [2:0]       state_q,    state_d;
  logic [15:0]      src_q,      src_d;
  logic [15:0]      dst_q,      dst_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [7:0]       data_q,     data_d;
  logic [TO_W-1:0]  tcnt_q,     tcnt_d;
  logic             err_flag_q, err_flag_d;

  logic             cmd_ready_q,  cmd_ready_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             err_q,        err_d;
  logic             busrq_n_q,    busrq_n_d;
  logic             bus_en_q,     bus_en_d;
  logic [15:0]      dma_a_q,      dma_a_d;
  logic [7:0]       dma_do_q,     dma_do_d;
  logic             mreq_n_q,     mreq_n_d;
  logic             rd_n_q,       rd_n_d;
  logic             wr_n_q,       wr_n_d;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    tcnt_d     = tcnt_q;
    err_flag_d = err_flag_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_d      = cmd_src;
          dst_d      = cmd_dst;
          cnt_d      = cmd_len;
          tcnt_d     = '0;
          err_flag_d = 1'b0;
          state_d    = (cmd_len == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        tcnt_d = tcnt_q + 1'b1;
        // A grant sampled on the timeout cycle still wins.
        if (!busak_n) begin
          state_d = S_RD1;
        end else if ((ACK_TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
          err_flag_d = 1'b1;
          state_d    = S_REL;
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        data_d  = dma_di;
        state_d = S_WR;
      end
      S_WR: begin
        src_d   = src_q + 16'd1;
        dst_d   = dst_q + 16'd1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CNT_W'(1)) ? S_REL : S_RD1;
      end
      S_REL: begin
        if (busak_n) state_d = S_FIN;
      end
      S_FIN: begin
        err_flag_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so each
    // registered output lines up with the state it belongs to.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FIN);
    err_d       = (state_d == S_FIN) && err_flag_d;
    busrq_n_d   = !((state_d == S_REQ) || (state_d == S_RD1) ||
                    (state_d == S_RD2) || (state_d == S_WR));
    bus_en_d    = (state_d == S_RD1) || (state_d == S_RD2) || (state_d == S_WR);
    mreq_n_d    = !bus_en_d;
    rd_n_d      = !((state_d == S_RD1) || (state_d == S_RD2));
    wr_n_d      = !(state_d == S_WR);

    dma_a_d  = dma_a_q;
    dma_do_d = dma_do_q;
    if ((state_d == S_RD1) || (state_d == S_RD2)) begin
      dma_a_d = src_d;
    end else if (state_d == S_WR) begin
      dma_a_d  = dst_d;
      dma_do_d = data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      tcnt_q      <= '0;
      err_flag_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busrq_n_q   <= 1'b1;
      bus_en_q    <= 1'b0;
      dma_a_q     <= '0;
      dma_do_q    <= '0;
      mreq_n_q    <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      tcnt_q      <= tcnt_d;
      err_flag_q  <= err_flag_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busrq_n_q   <= busrq_n_d;
      bus_en_q    <= bus_en_d;
      dma_a_q     <= dma_a_d;
      dma_do_q    <= dma_do_d;
      mreq_n_q    <= mreq_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busrq_n    = busrq_n_q;
  assign dma_bus_en = bus_en_q;
  assign dma_a      = dma_a_q;
  assign dma_do     = dma_do_q;
  assign dma_mreq_n = mreq_n_q;
  assign dma_rd_n   = rd_n_q;
  assign dma_wr_n   = wr_n_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_busrq_dma.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_z80_busrq_dma
// Description : Self-checking bench for z80_busrq_dma. Models a synchronous
//               memory on the DMA port and a CPU that answers busrq_n with
//               busak_n one cycle later (or holds the bus when cpu_hold=1).
//               Expected writes and done/err results are queued when a
//               command is issued and popped when the DUT produces them.
// Revision    : 1.0 - initial release
//============================================================================
module tb_z80_busrq_dma;

  localparam int CNT_W       = 16;
  localparam int ACK_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_src;
  logic [15:0]      cmd_dst;
  logic [CNT_W-1:0] cmd_len;
  logic             busy, done, err;
  logic             busrq_n, busak_n;
  logic             dma_bus_en;
  logic [15:0]      dma_a;
  logic [7:0]       dma_do, dma_di;
  logic             dma_mreq_n, dma_rd_n, dma_wr_n;
  logic             cpu_hold;

  always #5 clk = ~clk;

  z80_busrq_dma #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .busrq_n(busrq_n), .busak_n(busak_n),
    .dma_bus_en(dma_bus_en), .dma_a(dma_a), .dma_do(dma_do), .dma_di(dma_di),
    .dma_mreq_n(dma_mreq_n), .dma_rd_n(dma_rd_n), .dma_wr_n(dma_wr_n)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t  wq[$];
  logic dq[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [0:65535];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CPU: grants one cycle after the request, releases one cycle after it drops.
  always @(posedge clk) busak_n <= cpu_hold | busrq_n;

  // Memory behind the mux; the mux deselects the DMA while reset is high.
  always @(posedge clk) begin
    if (!reset && dma_bus_en && !dma_mreq_n) begin
      if (!dma_rd_n) dma_di <= mem[dma_a];
      if (!dma_wr_n) mem[dma_a] <= dma_do;
    end
  end

  wr_t e;
  always @(negedge clk) begin
    if (!reset && dma_bus_en && !dma_mreq_n && !dma_wr_n) begin
      chk("wr_expected", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_addr", 32'(dma_a), 32'(e.addr));
        chk("wr_data", 32'(dma_do), 32'(e.data));
      end
      chk("wr_busak", 32'(busak_n), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      chk("done_expected", 32'(dq.size() > 0), 32'd1);
      if (dq.size() > 0) chk("done_err", 32'(err), 32'(dq.pop_front()));
    end
    if (!reset && err && !done) chk("err_with_done", 32'(done), 32'd1);
  end

  task automatic push_copy(input logic [15:0] src, input logic [15:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      wq.push_back('{addr: dst + 16'(i), data: mem[src + 16'(i)]});
    end
  endtask

  task automatic issue(input logic [15:0] src, input logic [15:0] dst, input logic [CNT_W-1:0] len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // n = number of negedges after the accepting edge before done is seen.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 32'({busrq_n, dma_bus_en, dma_mreq_n, dma_rd_n, dma_wr_n,
                  done, err, busy, cmd_ready}), 32'(9'b1_0111_0001));
    chk({tag, "_a_do"}, 32'({dma_a, dma_do}), 32'd0);
  endtask

  int n;
  int lows;
  int nwr;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cpu_hold  = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    @(posedge clk);
    mem[16'h1000] <= 8'h11; mem[16'h1001] <= 8'h22; mem[16'h1002] <= 8'h33;
    mem[16'hFFFF] <= 8'hAA; mem[16'h0000] <= 8'hBB;
    mem[16'h3000] <= 8'h5A; mem[16'h3001] <= 8'hC3;
    mem[16'h4000] <= 8'h01; mem[16'h4001] <= 8'h02;
    mem[16'h4002] <= 8'h03; mem[16'h4003] <= 8'h04;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // 3-byte copy
    push_copy(16'h1000, 16'h2000, 3);
    dq.push_back(1'b0);
    issue(16'h1000, 16'h2000, 16'd3);
    chk("copy_busy", 32'({busy, cmd_ready}), 32'b10);
    wait_done(100, n);
    chk("copy_latency", 32'(n), 32'd13);
    chk("copy_busrq_released", 32'({busrq_n, busak_n}), 32'b11);
    @(negedge clk);
    chk("copy_idle", 32'({busy, cmd_ready, done}), 32'b010);
    chk("copy_mem", 32'({mem[16'h2000], mem[16'h2001], mem[16'h2002]}), 32'h112233);

    // null command: done the cycle after accept, no bus request
    dq.push_back(1'b0);
    issue(16'h1234, 16'h5678, 16'd0);
    chk("null_busrq", 32'(busrq_n), 32'd1);
    wait_done(10, n);
    chk("null_latency", 32'(n), 32'd0);
    chk("null_busrq_fin", 32'(busrq_n), 32'd1);

    // grant timeout: CPU never acknowledges
    cpu_hold = 1'b1;
    dq.push_back(1'b1);
    issue(16'h1000, 16'h6000, 16'd1);
    n = 0;
    lows = 0;
    while (n < 50) begin
      @(negedge clk);
      if (!busrq_n) lows++;
      if (done) break;
      n++;
    end
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_busrq_low_cycles", 32'(lows), 32'd4);
    chk("to_latency", 32'(n), 32'd5);
    chk("to_no_write", 32'(mem[16'h6000]), 32'd0);
    @(negedge clk);
    cpu_hold = 1'b0;
    chk("to_err_cleared", 32'({err, done, busy}), 32'd0);

    // address wrap at FFFF
    push_copy(16'hFFFF, 16'h7FFF, 2);
    dq.push_back(1'b0);
    issue(16'hFFFF, 16'h7FFF, 16'd2);
    wait_done(100, n);
    chk("wrap_latency", 32'(n), 32'd10);
    @(negedge clk);
    chk("wrap_mem", 32'({mem[16'h7FFF], mem[16'h8000]}), 32'hAABB);

    // second command during a transfer is dropped; next one after done runs
    push_copy(16'h3000, 16'h3100, 2);
    dq.push_back(1'b0);
    issue(16'h3000, 16'h3100, 16'd2);
    repeat (3) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_src   = 16'h5000;
    cmd_dst   = 16'h5100;
    cmd_len   = 16'd1;
    chk("busy_not_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(100, n);
    push_copy(16'h3000, 16'h3200, 1);
    dq.push_back(1'b0);
    issue(16'h3000, 16'h3200, 16'd1);
    wait_done(100, n);
    chk("b2b_latency", 32'(n), 32'd7);
    @(negedge clk);
    chk("b2b_mem", 32'({mem[16'h3100], mem[16'h3101], mem[16'h3200]}), 32'h5AC35A);
    chk("dropped_cmd_mem", 32'(mem[16'h5100]), 32'd0);

    // reset during the write of byte 2 of 4
    push_copy(16'h4000, 16'h4100, 1);
    issue(16'h4000, 16'h4100, 16'd4);
    nwr = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (!dma_wr_n) begin
        nwr++;
        if (nwr == 2) break;
      end
    end
    chk("rst_reached_wr2", 32'(nwr), 32'd2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("rst_midcopy");
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mem", 32'({mem[16'h4100], mem[16'h4101]}), 32'h0100);
    chk("rst_idle", 32'({busrq_n, busy, cmd_ready}), 32'b101);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
